mmio_uart_tx: RTL

- Memory-mapped serial transmit port that acts as a responder on the CPU data-memory bus (mem_addr, mem_wr_en, mem_wr_data, mem_rd_data), sitting beside RAM.
- CPU stores to DATA_ADDR push bytes into a small FIFO; an FSM serialises them as 8N1 UART frames on tx.
- A status register at STAT_ADDR lets firmware poll empty, full, busy and overflow; the system read mux selects this block's rd_data when rd_hit is high.

---
 rtl/mmio_uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small store FIFO and a pollable status register.
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | driving the start bit (0)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (1); chains straight into START if more bytes wait
module mmio_uart_tx #(
  parameter logic [7:0] DATA_ADDR    = 8'hFF,
  parameter logic [7:0] STAT_ADDR    = 8'hFE,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr_en,
  input  logic [7:0] mem_wr_data,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic pop, push_req, push_ok, stat_clr, baud_done, fifo_nonempty;

  assign baud_done     = (baud_q == BAUD_MAX);
  assign fifo_nonempty = (count_q != '0);
  assign push_req      = mem_wr_en && (mem_addr == DATA_ADDR);
  assign stat_clr      = mem_wr_en && (mem_addr == STAT_ADDR) && mem_wr_data[3];
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok       = push_req && ((count_q < DEPTH_C) || pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    // Set is applied after clear so a fresh overflow on the same edge survives.
    if (stat_clr)              ovf_d = 1'b0;
    if (push_req && !push_ok)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_q[wr_ptr_q] <= mem_wr_data;
  end

  assign tx      = tx_q;
  assign rd_hit  = (mem_addr == STAT_ADDR);
  assign rd_data = rd_hit ? {4'b0000, ovf_q, (state_q != S_IDLE), (count_q == DEPTH_C), !fifo_nonempty}
                          : 8'h00;

endmodule
